mem_arbiter_rr: RTL and testbench

Parametrised multi-port memory arbiter sitting between the core's memory requesters (fetch, load/store, debug/DMA) and the ROM, RAM and IO target interfaces. It generalises the two-port access block to NUM_PORTS requesters. It uses registered per-target grants with round-robin fairness, so requests on different targets proceed concurrently. Alignment, width and ROM-write errors are detected locally and never reach a target.

---
 rtl/mem_arbiter_rr.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
// Round-robin arbiter between NUM_PORTS memory requesters and the ROM, RAM
// and IO targets. Each target owns an independent IDLE/BUSY FSM and its own
// round-robin pointer, so requests that decode to different targets are
// serviced at the same time. Misaligned, illegal-width and ROM-write requests
// are answered locally one cycle after they are sampled and never reach a
// target.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | target free; all target outputs 0; searching for an eligible port
// BUSY  | request latched and driven with sel=1; waiting for finish_In
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   p_addr_In/p_data_In      per-port address / write data, 32 bits each
//   p_dataWidth_In           per-port width (00 byte, 01 half, 10 word)
//   p_isRead_In, p_valid_In  per-port direction and request valid
//   p_ok_Out                 per-port one-cycle completion pulse
//   p_data_Out               per-port read data, held until next completion
//   p_exception_Out          per-port completion status
//   rom_*/ram_*/io_*         target request outputs and response inputs
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int EXC_W     = 4,
    parameter logic [EXC_W-1:0] EXC_OK = 0,
    parameter logic [EXC_W-1:0] EXC_RD = 4,
    parameter logic [EXC_W-1:0] EXC_WR = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [32*NUM_PORTS-1:0]    p_addr_In,
    input  logic [32*NUM_PORTS-1:0]    p_data_In,
    input  logic [2*NUM_PORTS-1:0]     p_dataWidth_In,
    input  logic [NUM_PORTS-1:0]       p_isRead_In,
    input  logic [NUM_PORTS-1:0]       p_valid_In,
    output logic [NUM_PORTS-1:0]       p_ok_Out,
    output logic [32*NUM_PORTS-1:0]    p_data_Out,
    output logic [EXC_W*NUM_PORTS-1:0] p_exception_Out,
    output logic [31:0]                rom_addr_Out,
    output logic [1:0]                 rom_width_Out,
    output logic                       rom_sel_Out,
    input  logic                       rom_finish_In,
    input  logic [31:0]                rom_data_In,
    input  logic [EXC_W-1:0]           rom_exc_In,
    output logic [31:0]                ram_addr_Out,
    output logic [31:0]                ram_data_Out,
    output logic [1:0]                 ram_width_Out,
    output logic                       ram_isRead_Out,
    output logic                       ram_sel_Out,
    input  logic                       ram_finish_In,
    input  logic [31:0]                ram_data_In,
    input  logic [EXC_W-1:0]           ram_exc_In,
    output logic [31:0]                io_addr_Out,
    output logic [31:0]                io_data_Out,
    output logic [1:0]                 io_width_Out,
    output logic                       io_isRead_Out,
    output logic                       io_sel_Out,
    input  logic                       io_finish_In,
    input  logic [31:0]                io_data_In,
    input  logic [EXC_W-1:0]           io_exc_In
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NT    = 3;
    localparam logic [1:0] T_ROM = 2'd0;
    localparam logic [1:0] T_RAM = 2'd1;
    localparam logic [1:0] T_IO  = 2'd2;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q [NT];
    state_t             state_d [NT];
    logic [IDX_W-1:0]   port_q  [NT];
    logic [IDX_W-1:0]   port_d  [NT];
    logic [IDX_W-1:0]   last_q  [NT];
    logic [IDX_W-1:0]   last_d  [NT];
    logic [31:0]        addr_q  [NT];
    logic [31:0]        addr_d  [NT];
    logic [31:0]        data_q  [NT];
    logic [31:0]        data_d  [NT];
    logic [1:0]         width_q [NT];
    logic [1:0]         width_d [NT];
    logic               rd_q    [NT];
    logic               rd_d    [NT];

    logic [NT-1:0]      fin;
    logic [31:0]        fdata   [NT];
    logic [EXC_W-1:0]   fexc    [NT];

    logic [1:0]         tgt     [NUM_PORTS];
    logic [31:0]        fwd     [NUM_PORTS];
    logic [NUM_PORTS-1:0] lerr;
    logic [NUM_PORTS-1:0] elig  [NT];

    logic [NUM_PORTS-1:0]       ok_d;
    logic [32*NUM_PORTS-1:0]    rdata_d;
    logic [EXC_W*NUM_PORTS-1:0] exc_d;

    logic               hit;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;

    assign fin      = {io_finish_In, ram_finish_In, rom_finish_In};
    assign fdata[0] = rom_data_In;
    assign fdata[1] = ram_data_In;
    assign fdata[2] = io_data_In;
    assign fexc[0]  = rom_exc_In;
    assign fexc[1]  = ram_exc_In;
    assign fexc[2]  = io_exc_In;

    // Address decode, forwarded address and local error check per port.
    // Ports showing ok this cycle are still holding their finished request,
    // so they are masked from both the target and the local-error paths.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            tgt[i] = T_ROM;
            fwd[i] = {2'b00, p_addr_In[32*i +: 30]};
            case (p_addr_In[32*i+30 +: 2])
                2'b00: tgt[i] = T_ROM;
                2'b01: tgt[i] = T_RAM;
                2'b10: begin
                    tgt[i] = T_RAM;
                    fwd[i] = {2'b01, p_addr_In[32*i +: 30]};
                end
                default: tgt[i] = T_IO;
            endcase
            lerr[i] = (p_dataWidth_In[2*i +: 2] == 2'b11)
                   || ((p_dataWidth_In[2*i +: 2] == 2'b01) && p_addr_In[32*i])
                   || ((p_dataWidth_In[2*i +: 2] == 2'b10) && (p_addr_In[32*i +: 2] != 2'b00))
                   || (!p_isRead_In[i] && (tgt[i] == T_ROM));
        end
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                elig[t][i] = p_valid_In[i] && !lerr[i] && !p_ok_Out[i] && (tgt[i] == 2'(t));
            end
        end
    end

    always_comb begin : next_state
        ok_d    = '0;
        rdata_d = p_data_Out;
        exc_d   = p_exception_Out;
        hit     = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int t = 0; t < NT; t++) begin
            state_d[t] = state_q[t];
            port_d[t]  = port_q[t];
            last_d[t]  = last_q[t];
            addr_d[t]  = addr_q[t];
            data_d[t]  = data_q[t];
            width_d[t] = width_q[t];
            rd_d[t]    = rd_q[t];
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (p_valid_In[i] && lerr[i] && !p_ok_Out[i]) begin
                ok_d[i]                   = 1'b1;
                rdata_d[32*i +: 32]       = '0;
                exc_d[EXC_W*i +: EXC_W]   = p_isRead_In[i] ? EXC_RD : EXC_WR;
            end
        end

        for (int t = 0; t < NT; t++) begin
            case (state_q[t])
                S_IDLE: begin
                    hit  = 1'b0;
                    pick = '0;
                    for (int k = 1; k <= NUM_PORTS; k++) begin
                        cand = IDX_W'((int'(last_q[t]) + k) % NUM_PORTS);
                        if (!hit && elig[t][cand]) begin
                            hit  = 1'b1;
                            pick = cand;
                        end
                    end
                    if (hit) begin
                        state_d[t] = S_BUSY;
                        port_d[t]  = pick;
                        last_d[t]  = pick;
                        addr_d[t]  = fwd[pick];
                        data_d[t]  = p_data_In[32*pick +: 32];
                        width_d[t] = p_dataWidth_In[2*pick +: 2];
                        rd_d[t]    = p_isRead_In[pick];
                    end
                end
                S_BUSY: begin
                    if (fin[t]) begin
                        state_d[t]                           = S_IDLE;
                        ok_d[port_q[t]]                      = 1'b1;
                        rdata_d[32*port_q[t] +: 32]          = fdata[t];
                        exc_d[EXC_W*port_q[t] +: EXC_W]      = fexc[t];
                    end
                end
                default: state_d[t] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_ok_Out   <= '0;
            p_data_Out <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                p_exception_Out[EXC_W*i +: EXC_W] <= EXC_OK;
            end
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= S_IDLE;
                port_q[t]  <= '0;
                last_q[t]  <= '0;
                addr_q[t]  <= '0;
                data_q[t]  <= '0;
                width_q[t] <= '0;
                rd_q[t]    <= 1'b0;
            end
        end else begin
            p_ok_Out        <= ok_d;
            p_data_Out      <= rdata_d;
            p_exception_Out <= exc_d;
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= state_d[t];
                port_q[t]  <= port_d[t];
                last_q[t]  <= last_d[t];
                addr_q[t]  <= addr_d[t];
                data_q[t]  <= data_d[t];
                width_q[t] <= width_d[t];
                rd_q[t]    <= rd_d[t];
            end
        end
    end

    // Latched request registers are only visible while BUSY.
    assign rom_sel_Out    = (state_q[0] == S_BUSY);
    assign rom_addr_Out   = rom_sel_Out ? addr_q[0]  : '0;
    assign rom_width_Out  = rom_sel_Out ? width_q[0] : '0;

    assign ram_sel_Out    = (state_q[1] == S_BUSY);
    assign ram_addr_Out   = ram_sel_Out ? addr_q[1]  : '0;
    assign ram_data_Out   = ram_sel_Out ? data_q[1]  : '0;
    assign ram_width_Out  = ram_sel_Out ? width_q[1] : '0;
    assign ram_isRead_Out = ram_sel_Out && rd_q[1];

    assign io_sel_Out     = (state_q[2] == S_BUSY);
    assign io_addr_Out    = io_sel_Out ? addr_q[2]  : '0;
    assign io_data_Out    = io_sel_Out ? data_q[2]  : '0;
    assign io_width_Out   = io_sel_Out ? width_q[2] : '0;
    assign io_isRead_Out  = io_sel_Out && rd_q[2];

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // two-port instance
    logic [63:0] a_addr = '0, a_wdata = '0;
    logic [3:0]  a_width = '0;
    logic [1:0]  a_rd = '0, a_valid = '0;
    logic [1:0]  a_ok;
    logic [63:0] a_dout;
    logic [7:0]  a_exc;
    logic [31:0] a_rom_addr, a_ram_addr, a_ram_wdata, a_io_addr, a_io_wdata;
    logic [1:0]  a_rom_width, a_ram_width, a_io_width;
    logic        a_rom_sel, a_ram_sel, a_ram_rd, a_io_sel, a_io_rd;
    logic        a_rom_fin = 0, a_ram_fin = 0, a_io_fin = 0;
    logic [31:0] a_rom_data = '0, a_ram_data = '0, a_io_data = '0;
    logic [3:0]  a_rom_exc = '0, a_ram_exc = '0, a_io_exc = '0;

    // four-port instance
    logic [127:0] b_addr = '0, b_wdata = '0;
    logic [7:0]   b_width = '0;
    logic [3:0]   b_rd = '0, b_valid = '0;
    logic [3:0]   b_ok;
    logic [127:0] b_dout;
    logic [15:0]  b_exc;
    logic [31:0]  b_rom_addr, b_ram_addr, b_ram_wdata, b_io_addr, b_io_wdata;
    logic [1:0]   b_rom_width, b_ram_width, b_io_width;
    logic         b_rom_sel, b_ram_sel, b_ram_rd, b_io_sel, b_io_rd;
    logic         b_ram_fin = 0;
    logic [31:0]  b_ram_data = '0;

    mem_arbiter_rr #(.NUM_PORTS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .p_addr_In(a_addr), .p_data_In(a_wdata), .p_dataWidth_In(a_width),
        .p_isRead_In(a_rd), .p_valid_In(a_valid),
        .p_ok_Out(a_ok), .p_data_Out(a_dout), .p_exception_Out(a_exc),
        .rom_addr_Out(a_rom_addr), .rom_width_Out(a_rom_width), .rom_sel_Out(a_rom_sel),
        .rom_finish_In(a_rom_fin), .rom_data_In(a_rom_data), .rom_exc_In(a_rom_exc),
        .ram_addr_Out(a_ram_addr), .ram_data_Out(a_ram_wdata), .ram_width_Out(a_ram_width),
        .ram_isRead_Out(a_ram_rd), .ram_sel_Out(a_ram_sel),
        .ram_finish_In(a_ram_fin), .ram_data_In(a_ram_data), .ram_exc_In(a_ram_exc),
        .io_addr_Out(a_io_addr), .io_data_Out(a_io_wdata), .io_width_Out(a_io_width),
        .io_isRead_Out(a_io_rd), .io_sel_Out(a_io_sel),
        .io_finish_In(a_io_fin), .io_data_In(a_io_data), .io_exc_In(a_io_exc)
    );

    mem_arbiter_rr #(.NUM_PORTS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .p_addr_In(b_addr), .p_data_In(b_wdata), .p_dataWidth_In(b_width),
        .p_isRead_In(b_rd), .p_valid_In(b_valid),
        .p_ok_Out(b_ok), .p_data_Out(b_dout), .p_exception_Out(b_exc),
        .rom_addr_Out(b_rom_addr), .rom_width_Out(b_rom_width), .rom_sel_Out(b_rom_sel),
        .rom_finish_In(1'b0), .rom_data_In(32'h0), .rom_exc_In(4'h0),
        .ram_addr_Out(b_ram_addr), .ram_data_Out(b_ram_wdata), .ram_width_Out(b_ram_width),
        .ram_isRead_Out(b_ram_rd), .ram_sel_Out(b_ram_sel),
        .ram_finish_In(b_ram_fin), .ram_data_In(b_ram_data), .ram_exc_In(4'h0),
        .io_addr_Out(b_io_addr), .io_data_Out(b_io_wdata), .io_width_Out(b_io_width),
        .io_isRead_Out(b_io_rd), .io_sel_Out(b_io_sel),
        .io_finish_In(1'b0), .io_data_In(32'h0), .io_exc_In(4'h0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input int i, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] w, input logic rd, input logic v);
        a_addr[32*i +: 32]  = addr;
        a_wdata[32*i +: 32] = wd;
        a_width[2*i +: 2]   = w;
        a_rd[i]             = rd;
        a_valid[i]          = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({a_ok, a_dout, a_exc, a_rom_sel, a_ram_sel, a_io_sel, a_ram_addr, a_io_addr, a_rom_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ok=%b data=%h exc=%h sel=%b%b%b", a_ok, a_dout, a_exc,
                     a_rom_sel, a_ram_sel, a_io_sel);
        end
        total++;
        if ({b_ok, b_dout, b_ram_sel, b_ram_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs4 got ok=%b sel=%b addr=%h", b_ok, b_ram_sel, b_ram_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        a_set(0, 32'h4000_0010, 32'h0, 2'b10, 1'b1, 1'b1);
        step();
        total++;
        if (a_ram_sel !== 1'b1 || a_ram_addr !== 32'h0000_0010 || a_ram_rd !== 1'b1 || a_ram_width !== 2'b10) begin
            bad++;
            $display("FAIL single_req got sel=%b addr=%h rd=%b w=%b exp sel=1 addr=00000010 rd=1 w=10",
                     a_ram_sel, a_ram_addr, a_ram_rd, a_ram_width);
        end
        total++;
        if (a_ok !== 2'b00) begin
            bad++;
            $display("FAIL single_early_ok got=%b exp=00", a_ok);
        end
        a_ram_fin = 1'b1; a_ram_data = 32'hDEAD_BEEF; a_ram_exc = 4'h0;
        step();
        total++;
        if (a_ok !== 2'b01 || a_dout[31:0] !== 32'hDEAD_BEEF || a_exc[3:0] !== 4'd0 || a_ram_sel !== 1'b0) begin
            bad++;
            $display("FAIL single_done got ok=%b data=%h exc=%h sel=%b exp ok=01 data=deadbeef exc=0 sel=0",
                     a_ok, a_dout[31:0], a_exc[3:0], a_ram_sel);
        end
        a_ram_fin = 1'b0;
        a_valid = 2'b00;
        step();
        total++;
        if (a_ok !== 2'b00 || a_dout[31:0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_hold got ok=%b data=%h exp ok=00 data=deadbeef", a_ok, a_dout[31:0]);
        end
    endtask

    task automatic test_round_robin_io();
        logic [1:0] exp_ok;
        a_set(0, 32'hC000_0000, 32'h0, 2'b10, 1'b1, 1'b1);
        a_set(1, 32'hC000_0000, 32'h0, 2'b10, 1'b1, 1'b1);
        a_io_fin = 1'b1; a_io_data = 32'h0000_0055;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) exp_ok = 2'b00;
            else exp_ok = ((k / 2) % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if (a_ok !== exp_ok || a_io_sel !== 1'(k % 2)) begin
                bad++;
                $display("FAIL rr_io cycle=%0d got ok=%b sel=%b exp ok=%b sel=%0d", k, a_ok, a_io_sel, exp_ok, k % 2);
            end
        end
        a_valid = 2'b00;
        a_io_fin = 1'b0;
        step();
    endtask

    task automatic test_concurrent();
        a_set(0, 32'h0000_0100, 32'h0, 2'b10, 1'b1, 1'b1);
        a_set(1, 32'h8000_0004, 32'h1234_5678, 2'b10, 1'b0, 1'b1);
        step();
        total++;
        if (a_rom_sel !== 1'b1 || a_ram_sel !== 1'b1 || a_rom_addr !== 32'h0000_0100 ||
            a_ram_addr !== 32'h4000_0004 || a_ram_wdata !== 32'h1234_5678 || a_ram_rd !== 1'b0) begin
            bad++;
            $display("FAIL conc_sel got romsel=%b ramsel=%b romaddr=%h ramaddr=%h wdata=%h rd=%b",
                     a_rom_sel, a_ram_sel, a_rom_addr, a_ram_addr, a_ram_wdata, a_ram_rd);
        end
        a_rom_fin = 1'b1; a_rom_data = 32'hA5A5_0001; a_rom_exc = 4'h3;
        step();
        total++;
        if (a_ok !== 2'b01 || a_dout[31:0] !== 32'hA5A5_0001 || a_exc[3:0] !== 4'h3 ||
            a_rom_sel !== 1'b0 || a_ram_sel !== 1'b1) begin
            bad++;
            $display("FAIL conc_rom_done got ok=%b data=%h exc=%h romsel=%b ramsel=%b",
                     a_ok, a_dout[31:0], a_exc[3:0], a_rom_sel, a_ram_sel);
        end
        a_rom_fin = 1'b0; a_rom_exc = 4'h0;
        a_valid[0] = 1'b0;
        a_ram_fin = 1'b1; a_ram_data = 32'h0; a_ram_exc = 4'h0;
        step();
        total++;
        if (a_ok !== 2'b10 || a_exc[7:4] !== 4'h0 || a_ram_sel !== 1'b0 || a_dout[31:0] !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL conc_ram_done got ok=%b exc1=%h ramsel=%b data0=%h", a_ok, a_exc[7:4], a_ram_sel, a_dout[31:0]);
        end
        a_ram_fin = 1'b0;
        a_valid = 2'b00;
        step();
    endtask

    task automatic test_local_errors();
        a_set(0, 32'h4000_0001, 32'h0, 2'b01, 1'b0, 1'b1);
        a_set(1, 32'h4000_0000, 32'h0, 2'b11, 1'b1, 1'b1);
        step();
        total++;
        if (a_ok !== 2'b11 || a_exc !== 8'h46 || a_dout !== 64'h0 || {a_rom_sel, a_ram_sel, a_io_sel} !== 3'b000) begin
            bad++;
            $display("FAIL lerr_first got ok=%b exc=%h data=%h sel=%b%b%b exp ok=11 exc=46 data=0 sel=000",
                     a_ok, a_exc, a_dout, a_rom_sel, a_ram_sel, a_io_sel);
        end
        a_valid[1] = 1'b0;
        a_set(0, 32'h0000_0000, 32'h0, 2'b10, 1'b0, 1'b1);
        step();
        total++;
        if (a_ok !== 2'b00 || {a_rom_sel, a_ram_sel, a_io_sel} !== 3'b000) begin
            bad++;
            $display("FAIL lerr_masked got ok=%b sel=%b%b%b exp ok=00 sel=000", a_ok, a_rom_sel, a_ram_sel, a_io_sel);
        end
        step();
        total++;
        if (a_ok !== 2'b01 || a_exc[3:0] !== 4'd6 || {a_rom_sel, a_ram_sel, a_io_sel} !== 3'b000) begin
            bad++;
            $display("FAIL lerr_romwrite got ok=%b exc=%h sel=%b%b%b exp ok=01 exc=6 sel=000",
                     a_ok, a_exc[3:0], a_rom_sel, a_ram_sel, a_io_sel);
        end
        a_valid = 2'b00;
        step();
    endtask

    task automatic test_reset_mid_access();
        a_set(0, 32'h4000_0020, 32'h0, 2'b10, 1'b1, 1'b1);
        step();
        total++;
        if (a_ram_sel !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_busy got sel=%b exp=1", a_ram_sel);
        end
        rst = 1'b1;
        a_valid = 2'b00;
        step();
        total++;
        if (a_ram_sel !== 1'b0 || a_ok !== 2'b00 || a_ram_addr !== 32'h0 || a_dout !== 64'h0) begin
            bad++;
            $display("FAIL rst_mid_drop got sel=%b ok=%b addr=%h data=%h", a_ram_sel, a_ok, a_ram_addr, a_dout);
        end
        rst = 1'b0;
        step();
        a_ram_fin = 1'b1; a_ram_data = 32'hFFFF_FFFF;
        step();
        total++;
        if (a_ok !== 2'b00 || a_ram_sel !== 1'b0 || a_dout !== 64'h0) begin
            bad++;
            $display("FAIL rst_mid_late_finish got ok=%b sel=%b data=%h exp ok=00 sel=0 data=0", a_ok, a_ram_sel, a_dout);
        end
        a_ram_fin = 1'b0;
        step();
    endtask

    task automatic test_four_port_ram();
        int order [4];
        order = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            b_addr[32*i +: 32] = 32'h4000_0000 + 32'(4 * i);
            b_width[2*i +: 2]  = 2'b10;
        end
        b_rd = 4'hF;
        b_valid = 4'hF;
        step();
        for (int n = 0; n < 4; n++) begin
            total++;
            if (b_ram_sel !== 1'b1 || b_ram_addr !== 32'(4 * order[n]) || b_ok !== 4'h0) begin
                bad++;
                $display("FAIL rr4_grant n=%0d got sel=%b addr=%h ok=%b exp sel=1 addr=%h ok=0000",
                         n, b_ram_sel, b_ram_addr, b_ok, 4 * order[n]);
            end
            step();
            step();
            total++;
            if (b_ok !== 4'h0 || b_ram_sel !== 1'b1) begin
                bad++;
                $display("FAIL rr4_wait n=%0d got ok=%b sel=%b exp ok=0000 sel=1", n, b_ok, b_ram_sel);
            end
            b_ram_fin = 1'b1; b_ram_data = 32'h100 + 32'(order[n]);
            step();
            total++;
            if (b_ok !== 4'(1 << order[n]) || b_ram_sel !== 1'b0 ||
                b_dout[32*order[n] +: 32] !== 32'h100 + 32'(order[n])) begin
                bad++;
                $display("FAIL rr4_done n=%0d got ok=%b sel=%b data=%h exp ok=%b sel=0",
                         n, b_ok, b_ram_sel, b_dout[32*order[n] +: 32], 4'(1 << order[n]));
            end
            b_ram_fin = 1'b0;
            b_valid[order[n]] = 1'b0;
            step();
        end
        total++;
        if (b_ok !== 4'h0 || b_ram_sel !== 1'b0) begin
            bad++;
            $display("FAIL rr4_end got ok=%b sel=%b exp ok=0000 sel=0", b_ok, b_ram_sel);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin_io();
        test_concurrent();
        test_local_errors();
        test_reset_mid_access();
        test_four_port_ram();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
